fsm_timer_ctrl: RTL and testbench

Sequencing controller for the lab 3 pattern-triggered timer. It watches the serial `data` line for the start pattern 1101 and then asserts `shift_ena` for exactly four cycles to capture a 4-bit delay value, MSB first. It then runs a counting phase of (delay+1)×BLOCK_CYCLES cycles and raises `done` until the user acknowledges. The block contains the controller FSM plus its own delay register and counters, and sits directly behind the top-level `clk`/`reset`/`data` pins.

---
 rtl/fsm_timer_ctrl.sv | 116 +++++++++++
 tb/tb_fsm_timer_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_timer_ctrl.sv
// fsm_timer_ctrl: pattern-triggered timer controller.
// Finds 1101 on the serial data line (overlapping detection) and shifts in a
// 4-bit delay, MSB first. It then counts (delay+1)*BLOCK_CYCLES cycles and
// holds done until the user acknowledges.
module fsm_timer_ctrl #(
  parameter int BLOCK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data,
  input  logic       ack,
  output logic       shift_ena,
  output logic       counting,
  output logic       done,
  output logic [3:0] count
);

  localparam int CW = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(BLOCK_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [3:0] {
    S0,
    S1,
    S11,
    S110,
    SH0,
    SH1,
    SH2,
    SH3,
    CNT,
    WAIT_ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;

  // Controller: state, delay register, cycle counter and registered Moore outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S0;
      shift_ena <= 1'b0;
      counting  <= 1'b0;
      done      <= 1'b0;
      count     <= 4'd0;
      cyc_cnt   <= '0;
    end else begin
      case (state)
        S0: begin
          state <= data ? S1 : S0;
        end
        S1: begin
          state <= data ? S11 : S0;
        end
        S11: begin
          state <= data ? S11 : S110;
        end
        S110: begin
          if (data) begin
            state     <= SH0;
            shift_ena <= 1'b1;
          end else begin
            state <= S0;
          end
        end
        SH0: begin
          count <= {count[2:0], data};
          state <= SH1;
        end
        SH1: begin
          count <= {count[2:0], data};
          state <= SH2;
        end
        SH2: begin
          count <= {count[2:0], data};
          state <= SH3;
        end
        SH3: begin
          count     <= {count[2:0], data};
          state     <= CNT;
          shift_ena <= 1'b0;
          counting  <= 1'b1;
          cyc_cnt   <= '0;
        end
        CNT: begin
          if (cyc_cnt == LAST_CYC) begin
            cyc_cnt <= '0;
            if (count != 4'd0) begin
              count <= count - 4'd1;
            end else begin
              state    <= WAIT_ACK;
              counting <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            state <= S0;
            done  <= 1'b0;
          end
        end
        default: begin
          state     <= S0;
          shift_ena <= 1'b0;
          counting  <= 1'b0;
          done      <= 1'b0;
          cyc_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_timer_ctrl.sv
// tb_fsm_timer_ctrl: directed and random stimulus against a phase-level
// reference model. Every stimulus cycle queues the expected outputs, and a
// monitor compares them on the following falling edge.
module tb_fsm_timer_ctrl;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data = 1'b0;
  logic       ack = 1'b0;
  logic       shift_ena;
  logic       counting;
  logic       done;
  logic [3:0] count;

  fsm_timer_ctrl #(.BLOCK_CYCLES(B)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .ack      (ack),
    .shift_ena(shift_ena),
    .counting (counting),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       se;
    logic       cn;
    logic       dn;
    logic [3:0] cnt;
  } exp_t;

  typedef enum int {PH_SEARCH, PH_SHIFT, PH_COUNT, PH_DONE} phase_t;

  // Reference model: phase plus plain integer bookkeeping
  phase_t     ph;
  logic [3:0] hist;
  int         hist_len;
  int         shift_n;
  int         delay_val;
  int         elapsed;
  int         count_val;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_idx = 0;

  function automatic void modelReset();
    ph        = PH_SEARCH;
    hist      = 4'd0;
    hist_len  = 0;
    shift_n   = 0;
    delay_val = 0;
    elapsed   = 0;
    count_val = 0;
  endfunction

  // Effect of one clock edge that samples data=d, ack=a
  function automatic void modelStep(input logic d, input logic a);
    case (ph)
      PH_SEARCH: begin
        hist = {hist[2:0], d};
        hist_len++;
        if (hist_len >= 4 && hist == 4'b1101) begin
          ph      = PH_SHIFT;
          shift_n = 0;
        end
      end
      PH_SHIFT: begin
        count_val = ((count_val * 2) + (d ? 1 : 0)) % 16;
        shift_n++;
        if (shift_n == 4) begin
          ph        = PH_COUNT;
          delay_val = count_val;
          elapsed   = 0;
        end
      end
      PH_COUNT: begin
        elapsed++;
        if (elapsed == (delay_val + 1) * B) begin
          ph        = PH_DONE;
          count_val = 0;
        end else begin
          count_val = delay_val - (elapsed / B);
        end
      end
      PH_DONE: begin
        if (a) begin
          ph       = PH_SEARCH;
          hist_len = 0;
        end
      end
      default: ph = PH_SEARCH;
    endcase
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    e.se  = (ph == PH_SHIFT);
    e.cn  = (ph == PH_COUNT);
    e.dn  = (ph == PH_DONE);
    e.cnt = 4'(count_val);
    return e;
  endfunction

  function automatic exp_t dutOut();
    return {shift_ena, counting, done, count};
  endfunction

  task automatic checkOutput(input string name, input exp_t got, input exp_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got se=%b cn=%b dn=%b cnt=%0d, expected se=%b cn=%b dn=%b cnt=%0d",
               name, got.se, got.cn, got.dn, got.cnt, want.se, want.cn, want.dn, want.cnt);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic a);
    @(negedge clk);
    #1;
    data = d;
    ack  = a;
    modelStep(d, a);
    exp_q.push_back(modelOut());
  endtask

  task automatic sendNibble(input logic [3:0] bits, input logic a);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(bits[i], a);
    end
  endtask

  task automatic idleCycles(input int n, input logic a);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom), a);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", dutOut(), '0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_hold", dutOut(), '0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    data  = 1'b0;
    ack   = 1'b0;
    modelReset();
    modelStep(1'b0, 1'b0);
    exp_q.push_back(modelOut());
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc_idx++;
        checkOutput($sformatf("cycle%0d", cyc_idx), dutOut(), e);
      end
    end
  end

  initial begin
    modelReset();
    resetDut();

    // No false trigger
    sendNibble(4'b1100, 1'b0);
    sendNibble(4'b1011, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Basic run, delay 5
    sendNibble(4'b1101, 1'b0);
    sendNibble(4'b0101, 1'b0);
    idleCycles(26, 1'b0);
    applyStimulus(1'b0, 1'b1);
    idleCycles(2, 1'b0);

    // Overlapping pattern, delay 0
    applyStimulus(1'b1, 1'b0);
    sendNibble(4'b1101, 1'b0);
    sendNibble(4'b0000, 1'b0);
    idleCycles(6, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);

    // Max delay with ack toggling while counting
    sendNibble(4'b1101, 1'b0);
    sendNibble(4'b1111, 1'b0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'($urandom), 1'($urandom));
    end
    idleCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);

    // Reset ten cycles into counting, then delay 2
    sendNibble(4'b1101, 1'b0);
    sendNibble({1'b1, 3'($urandom)}, 1'b0);
    idleCycles(10, 1'b0);
    resetDut();
    sendNibble(4'b1101, 1'b0);
    sendNibble(4'b0010, 1'b0);
    idleCycles(14, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);

    // Ack held high before expiry
    sendNibble(4'b1101, 1'b0);
    sendNibble(4'b0001, 1'b1);
    idleCycles(10, 1'b1);
    idleCycles(3, 1'b0);

    // Pattern during done phase must not trigger afterwards
    sendNibble(4'b1101, 1'b0);
    sendNibble(4'b0000, 1'b0);
    idleCycles(5, 1'b0);
    sendNibble(4'b1101, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
